// File: rtl/rvx_bus_arbiter.sv
// Two-requester (ibus/dbus) arbiter onto one RAM-style memory port, with response watchdog.
// Define RVX_BUS_ARBITER_ROUND_ROBIN_EN for round-robin grant on collisions (default: D over I).
module rvx_bus_arbiter #(
  parameter int unsigned MAX_WAIT      = 255,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] ibus_address,
  input  logic                     ibus_rrequest,
  output logic [31:0]              ibus_rdata,
  output logic                     ibus_rresponse,
  input  logic [ADDRESS_WIDTH-1:0] dbus_address,
  input  logic                     dbus_rrequest,
  input  logic                     dbus_wrequest,
  input  logic [31:0]              dbus_wdata,
  input  logic [3:0]               dbus_wstrobe,
  output logic [31:0]              dbus_rdata,
  output logic                     dbus_rresponse,
  output logic                     dbus_wresponse,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_rrequest,
  output logic                     mem_wrequest,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrobe,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rresponse,
  input  logic                     mem_wresponse,
  output logic                     timeout_error
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     kind_w_q, kind_w_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     i_valid_q, i_valid_d;
  logic [ADDRESS_WIDTH-1:0] i_addr_q, i_addr_d;
  logic                     d_valid_q, d_valid_d;
  logic                     d_write_q, d_write_d;
  logic [ADDRESS_WIDTH-1:0] d_addr_q, d_addr_d;
  logic [31:0]              d_wdata_q, d_wdata_d;
  logic [3:0]               d_wstrobe_q, d_wstrobe_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                     mem_rrequest_q, mem_rrequest_d;
  logic                     mem_wrequest_q, mem_wrequest_d;
  logic [31:0]              mem_wdata_q, mem_wdata_d;
  logic [3:0]               mem_wstrobe_q, mem_wstrobe_d;
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
  logic                     last_d_q, last_d_d;
`endif

  logic busy_c, resp_ok_c, timeout_c, done_c;
  logic i_load_c, d_load_c, i_avail_c, d_avail_c, grant_d_c, grant_i_c;

  // Completion detection; reset masks any response forwarding
  always_comb begin
    busy_c    = (state_q == BUSY);
    resp_ok_c = busy_c && !reset && (kind_w_q ? mem_wresponse : mem_rresponse);
    timeout_c = busy_c && !reset && (MAX_WAIT != 0) && !resp_ok_c &&
                (cnt_q == CNT_W'(MAX_WAIT));
    done_c    = resp_ok_c || timeout_c;
  end

  // Requests into an occupied slot are dropped; slots loading this edge are already eligible
  always_comb begin
    i_load_c  = ibus_rrequest && !i_valid_q;
    d_load_c  = (dbus_rrequest || dbus_wrequest) && !d_valid_q;
    i_avail_c = i_load_c || (i_valid_q && !(busy_c && owner_q == OWN_I));
    d_avail_c = d_load_c || (d_valid_q && !(busy_c && owner_q == OWN_D));
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
    grant_d_c = d_avail_c && (!i_avail_c || !last_d_q);
`else
    grant_d_c = d_avail_c;
`endif
    grant_i_c = i_avail_c && !grant_d_c;
  end

  // Next-state: slot capture, completion, and issue (back-to-back issue on the completion edge)
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    kind_w_d       = kind_w_q;
    cnt_d          = cnt_q;
    i_valid_d      = i_valid_q;
    i_addr_d       = i_addr_q;
    d_valid_d      = d_valid_q;
    d_write_d      = d_write_q;
    d_addr_d       = d_addr_q;
    d_wdata_d      = d_wdata_q;
    d_wstrobe_d    = d_wstrobe_q;
    mem_address_d  = mem_address_q;
    mem_rrequest_d = 1'b0;
    mem_wrequest_d = 1'b0;
    mem_wdata_d    = mem_wdata_q;
    mem_wstrobe_d  = mem_wstrobe_q;
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
    last_d_d       = last_d_q;
`endif

    if (i_load_c) begin
      i_valid_d = 1'b1;
      i_addr_d  = ibus_address;
    end
    if (d_load_c) begin
      d_valid_d   = 1'b1;
      d_write_d   = dbus_wrequest;
      d_addr_d    = dbus_address;
      d_wdata_d   = dbus_wdata;
      d_wstrobe_d = dbus_wstrobe;
    end

    if (done_c) begin
      state_d = IDLE;
      if (owner_q == OWN_I) i_valid_d = 1'b0;
      else                  d_valid_d = 1'b0;
    end else if (busy_c && MAX_WAIT != 0) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if ((!busy_c || done_c) && (grant_d_c || grant_i_c)) begin
      state_d = BUSY;
      cnt_d   = '0;
      owner_d = grant_d_c ? OWN_D : OWN_I;
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
      last_d_d = grant_d_c;
`endif
      if (grant_d_c) begin
        kind_w_d      = d_load_c ? dbus_wrequest : d_write_q;
        mem_address_d = d_load_c ? dbus_address  : d_addr_q;
        mem_wdata_d   = d_load_c ? dbus_wdata    : d_wdata_q;
        mem_wstrobe_d = d_load_c ? dbus_wstrobe  : d_wstrobe_q;
      end else begin
        kind_w_d      = 1'b0;
        mem_address_d = i_load_c ? ibus_address : i_addr_q;
        mem_wdata_d   = '0;
        mem_wstrobe_d = '0;
      end
      mem_rrequest_d = !kind_w_d;
      mem_wrequest_d = kind_w_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_I;
      kind_w_q       <= 1'b0;
      cnt_q          <= '0;
      i_valid_q      <= 1'b0;
      i_addr_q       <= '0;
      d_valid_q      <= 1'b0;
      d_write_q      <= 1'b0;
      d_addr_q       <= '0;
      d_wdata_q      <= '0;
      d_wstrobe_q    <= '0;
      mem_address_q  <= '0;
      mem_rrequest_q <= 1'b0;
      mem_wrequest_q <= 1'b0;
      mem_wdata_q    <= '0;
      mem_wstrobe_q  <= '0;
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
      last_d_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      kind_w_q       <= kind_w_d;
      cnt_q          <= cnt_d;
      i_valid_q      <= i_valid_d;
      i_addr_q       <= i_addr_d;
      d_valid_q      <= d_valid_d;
      d_write_q      <= d_write_d;
      d_addr_q       <= d_addr_d;
      d_wdata_q      <= d_wdata_d;
      d_wstrobe_q    <= d_wstrobe_d;
      mem_address_q  <= mem_address_d;
      mem_rrequest_q <= mem_rrequest_d;
      mem_wrequest_q <= mem_wrequest_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrobe_q  <= mem_wstrobe_d;
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
      last_d_q       <= last_d_d;
`endif
    end
  end

  // Responses are forwarded in the same cycle as the memory completion
  always_comb begin
    ibus_rresponse = done_c && (owner_q == OWN_I);
    dbus_rresponse = done_c && (owner_q == OWN_D) && !kind_w_q;
    dbus_wresponse = done_c && (owner_q == OWN_D) && kind_w_q;
    ibus_rdata     = (ibus_rresponse && resp_ok_c) ? mem_rdata : 32'd0;
    dbus_rdata     = (dbus_rresponse && resp_ok_c) ? mem_rdata : 32'd0;
    timeout_error  = timeout_c;
  end

  assign mem_address  = mem_address_q;
  assign mem_rrequest = mem_rrequest_q;
  assign mem_wrequest = mem_wrequest_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrobe  = mem_wstrobe_q;

endmodule

// File: doc/rvx_bus_arbiter.md
Name: rvx_bus_arbiter

Overview:
- Shares one memory port (read/write, RAM-style request/response) between the core's instruction bus and data bus.
- Lets an rvx_core run against a single-port memory or peripheral bridge instead of the dual-port rvx_ram.
- Latches each requester's transaction, picks one, sequences a single downstream access, and routes the response back to the owner.
- Includes a response watchdog.

Parameters:
- MAX_WAIT, 255: cycles allowed between downstream request and response before timeout; 0 disables the watchdog.
- ADDRESS_WIDTH, 32: width of all address ports.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ibus_address  input  ADDRESS_WIDTH  instruction fetch address, sampled with ibus_rrequest.
- ibus_rrequest  input  1  single-cycle fetch request pulse.
- ibus_rdata  output  32  fetch data, valid while ibus_rresponse=1.
- ibus_rresponse  output  1  single-cycle fetch completion.
- dbus_address  input  ADDRESS_WIDTH  data address, sampled with either dbus request.
- dbus_rrequest  input  1  single-cycle load request pulse.
- dbus_wrequest  input  1  single-cycle store request pulse.
- dbus_wdata  input  32  store data, sampled with dbus_wrequest.
- dbus_wstrobe  input  4  byte enables, sampled with dbus_wrequest.
- dbus_rdata  output  32  load data, valid while dbus_rresponse=1.
- dbus_rresponse  output  1  single-cycle load completion.
- dbus_wresponse  output  1  single-cycle store completion.
- mem_address  output  ADDRESS_WIDTH  downstream address.
- mem_rrequest  output  1  downstream read pulse.
- mem_wrequest  output  1  downstream write pulse.
- mem_wdata  output  32  downstream write data.
- mem_wstrobe  output  4  downstream byte enables.
- mem_rdata  input  32  downstream read data.
- mem_rresponse  input  1  downstream read completion.
- mem_wresponse  input  1  downstream write completion.
- timeout_error  output  1  single-cycle pulse when a downstream access exceeds MAX_WAIT.

Behaviour:
- Pending slots:
  - One slot per requester (I-slot, D-slot), each with address, kind (R/W), wdata and wstrobe.
  - A request pulse loads its slot on that edge.
  - A request arriving while that requester's slot is occupied or in flight is a protocol violation: it is ignored and the slot is left unchanged.
  - dbus_rrequest and dbus_wrequest together is illegal: the write is captured and the read dropped.
- FSM state IDLE:
  - If any slot is full, select one (priority below) and register mem_* outputs.
  - The mem_rrequest or mem_wrequest pulse is high for exactly one cycle, on the cycle after selection.
  - Record the owner, clear the wait counter, go to BUSY.
  - A slot loaded on edge N is eligible at edge N, so the earliest mem request is at cycle N+1.
- FSM state BUSY:
  - mem_address, mem_wdata and mem_wstrobe are held stable.
  - On mem_rresponse (read) or mem_wresponse (write), forward the response combinationally in the same cycle to the owner: ibus_rresponse, dbus_rresponse or dbus_wresponse.
  - Owner rdata = mem_rdata in that cycle; the non-owner's rdata = 0.
  - Free the owner's slot and return to IDLE. The next access may issue on the following cycle.
  - A response of the wrong kind, or in IDLE, is ignored.
- Priority, default: fixed, D-slot over I-slot.
- Watchdog:
  - In BUSY the counter increments each cycle.
  - When it reaches MAX_WAIT (MAX_WAIT≠0) without a response:
    - pulse timeout_error;
    - pulse the owner's response with rdata=0;
    - free the slot and go to IDLE.
  - A late mem response after timeout is ignored.
- Reset:
  - All outputs 0, both slots empty, FSM in IDLE, counter 0.
  - Reset mid-transaction drops the in-flight access.
  - A downstream response in the cycle after reset is ignored.
- Throughput: one access per 2 cycles minimum with a 1-cycle-latency memory.

Optional Feature:
- Macro: RVX_BUS_ARBITER_ROUND_ROBIN_EN.
- Defined: when both slots are full in IDLE, grant the requester not granted last time. The last-grant register resets to "ibus", so D is first after reset.
- Undefined: fixed D-over-I priority; the last-grant register is absent.

Test Plan:
- Single fetch:
  - Stimulus: ibus_rrequest at cycle 0, address 0x100, memory answers 1 cycle after request with 0xDEADBEEF.
  - Required: mem_rrequest at cycle 1 with mem_address 0x100; ibus_rresponse at cycle 2 with rdata 0xDEADBEEF; dbus outputs 0.
- Collision:
  - Stimulus: ibus read 0x200 and dbus write 0x300 (wdata 0x12345678, wstrobe 0xF) in the same cycle.
  - Required without the macro: write issued first, dbus_wresponse, then the read, then ibus_rresponse.
  - Required with the macro: first grant D, second grant I; after a later D-only access, the next collision grants I first.
- Back-pressure:
  - Stimulus: a second ibus_rrequest (address 0x400) while the first fetch (0x100) is in BUSY.
  - Required: the second request is ignored; only one mem_rrequest, for 0x100, is issued.
- Timeout:
  - Stimulus: MAX_WAIT=4, memory never responds to a dbus read.
  - Required: 4 cycles after mem_rrequest, timeout_error and dbus_rresponse pulse with rdata 0; a later mem_rresponse is ignored.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle while in BUSY.
  - Required: all outputs 0; a mem_rresponse in the next cycle produces no ibus or dbus response; new requests are served normally afterwards.
- Illegal dual dbus request:
  - Stimulus: rrequest and wrequest pulsed together, address 0x80.
  - Required: one mem_wrequest to 0x80, no mem_rrequest, a single dbus_wresponse.
